// File: rtl/motor_step_pkg.sv
// motor_step_pkg
// Shared definitions for the stepper step/dir generator: register offsets
// inside the window, CONTROL bit positions, the sequencer state enum and a
// small helper that applies the minimum step period.
package motor_step_pkg;

    // Register offsets relative to the block's base address
    localparam logic [5:0] REG_PERIOD  = 6'd0;
    localparam logic [5:0] REG_STEPS   = 6'd1;
    localparam logic [5:0] REG_CONTROL = 6'd2;

    // CONTROL register bit positions
    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_ES_EN    = 2;
    localparam int CTRL_ES_LEVEL = 3;

    typedef enum logic [2:0] {
        IDLE,
        DIR_SETUP,
        STEP_HIGH,
        STEP_LOW,
        FINISH
    } state_t;

    // A period shorter than the minimum would leave no room for the low phase
    function automatic logic [31:0] effective_period(input logic [31:0] period,
                                                     input logic [31:0] min_period);
        return (period < min_period) ? min_period : period;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous input (endstop pins).
// Ports:
//   clk   - destination clock
//   rst   - asynchronous active-high reset, forces the output to RESET_VALUE
//   d     - asynchronous input
//   q     - synchronized output, two clock cycles of latency
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // The first flop may go metastable; the second gives it a full cycle to settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/motor_step_gen.sv
// motor_step_gen
// Turns register writes from the executor's external register port into a
// step/dir/enable waveform for one stepper driver, watches one endstop and
// emits a one-cycle completion pulse per move.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   reg_addr/data   - write address and data, qualified by reg_stb
//   reg_busy        - high in the cycle after an accepted write
//   endstop         - raw endstop pin
//   mot_step/dir    - step pulse and direction to the driver
//   mot_enable      - driver enable, active-low
//   move_active     - a move is in progress
//   endstop_hit     - sticky flag: last move was stopped by the endstop
//   done_int        - one-cycle pulse at the end of every move
module motor_step_gen
    import motor_step_pkg::*;
#(
    parameter logic [5:0]  BASE_ADDR         = 6'h00,
    parameter int unsigned STEP_PULSE_CYCLES = 100,
    parameter int unsigned DIR_SETUP_CYCLES  = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  reg_addr,
    input  logic [31:0] reg_data,
    input  logic        reg_stb,
    output logic        reg_busy,
    input  logic        endstop,
    output logic        mot_step,
    output logic        mot_dir,
    output logic        mot_enable,
    output logic        move_active,
    output logic        endstop_hit,
    output logic        done_int
);

    localparam logic [31:0] PULSE_LEN  = 32'(STEP_PULSE_CYCLES);
    localparam logic [31:0] PULSE_LOAD = PULSE_LEN - 32'd1;
    localparam logic [31:0] DIR_LOAD   = 32'(DIR_SETUP_CYCLES) - 32'd1;
    localparam logic [31:0] MIN_PERIOD = 32'(2 * STEP_PULSE_CYCLES);

    state_t      state, next_state;
    logic [31:0] period_reg;
    logic        ctrl_enable, ctrl_es_en, ctrl_es_level;
    logic        abort_pending;
    logic [31:0] phase_cnt;
    logic [31:0] low_len;
    logic [30:0] step_cnt;
    logic        dir_reg, endstop_hit_reg, done_reg, busy_reg;

    logic        endstop_sync;
    logic [5:0]  offset;
    logic        accept, wr_period, wr_steps, wr_control;
    logic        stop_req, es_stop, phase_done;

    sync_2ff #(.RESET_VALUE(1'b0)) u_endstop_sync (
        .clk (clk),
        .rst (rst),
        .d   (endstop),
        .q   (endstop_sync)
    );

    // Address decode: the window is three registers wide, and a strobe that
    // lands in the busy cycle is simply lost. Abort is honoured both from the
    // explicit abort bit and from dropping enable mid-move.
    always_comb begin
        offset     = reg_addr - BASE_ADDR;
        accept     = reg_stb && (offset < 6'd3) && !busy_reg;
        wr_period  = accept && (offset == REG_PERIOD);
        wr_steps   = accept && (offset == REG_STEPS);
        wr_control = accept && (offset == REG_CONTROL);
        stop_req   = abort_pending || !ctrl_enable;
        es_stop    = ctrl_es_en && (endstop_sync == ctrl_es_level);
        phase_done = (phase_cnt == 32'd0);
    end

    // Next-state logic. A STEPS write is only looked at in IDLE, which is what
    // drops writes that arrive while a move runs. STEP_HIGH ignores abort and
    // endstop so that a pulse is never cut short.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wr_steps) begin
                    if ((reg_data[30:0] != 31'd0) && ctrl_enable)
                        next_state = DIR_SETUP;
                    else
                        next_state = FINISH;
                end
            end
            DIR_SETUP: begin
                if (stop_req || es_stop)
                    next_state = FINISH;
                else if (phase_done)
                    next_state = STEP_HIGH;
            end
            STEP_HIGH: begin
                if (phase_done)
                    next_state = STEP_LOW;
            end
            STEP_LOW: begin
                if (stop_req || es_stop)
                    next_state = FINISH;
                else if (phase_done)
                    next_state = (step_cnt == 31'd0) ? FINISH : STEP_HIGH;
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // All state: registers, sequencer state and the phase/step counters.
    // The phase counter is loaded with (length - 1) on entry to a timed state
    // and the state is left the cycle it reads zero. done_int is registered
    // off FINISH, so it appears one cycle after the sequencer passes through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            period_reg      <= 32'd0;
            ctrl_enable     <= 1'b0;
            ctrl_es_en      <= 1'b0;
            ctrl_es_level   <= 1'b0;
            abort_pending   <= 1'b0;
            phase_cnt       <= 32'd0;
            low_len         <= 32'd0;
            step_cnt        <= 31'd0;
            dir_reg         <= 1'b0;
            endstop_hit_reg <= 1'b0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state    <= next_state;
            busy_reg <= accept;
            done_reg <= (state == FINISH);

            if (wr_period)
                period_reg <= reg_data;

            if (wr_control) begin
                ctrl_enable   <= reg_data[CTRL_ENABLE];
                ctrl_es_en    <= reg_data[CTRL_ES_EN];
                ctrl_es_level <= reg_data[CTRL_ES_LEVEL];
            end

            if (!move_active)
                abort_pending <= 1'b0;
            if (wr_control && reg_data[CTRL_ABORT] && move_active)
                abort_pending <= 1'b1;

            if ((state == DIR_SETUP || state == STEP_LOW) && es_stop)
                endstop_hit_reg <= 1'b1;

            if (next_state != state) begin
                case (next_state)
                    DIR_SETUP: begin
                        phase_cnt       <= DIR_LOAD;
                        step_cnt        <= reg_data[30:0];
                        dir_reg         <= reg_data[31];
                        low_len         <= effective_period(period_reg, MIN_PERIOD) - PULSE_LEN;
                        endstop_hit_reg <= 1'b0;
                    end
                    STEP_HIGH: begin
                        phase_cnt <= PULSE_LOAD;
                        step_cnt  <= step_cnt - 31'd1;
                    end
                    STEP_LOW: phase_cnt <= low_len - 32'd1;
                    default:  phase_cnt <= 32'd0;
                endcase
            end else if (!phase_done) begin
                phase_cnt <= phase_cnt - 32'd1;
            end
        end
    end

    // Outputs follow state directly so the step pulse edges line up with
    // the state transitions.
    always_comb begin
        mot_step    = (state == STEP_HIGH);
        move_active = (state != IDLE) && (state != FINISH);
        mot_dir     = dir_reg;
        mot_enable  = ~ctrl_enable;
        endstop_hit = endstop_hit_reg;
        done_int    = done_reg;
        reg_busy    = busy_reg;
    end

endmodule

// File: tb/tb_motor_step_gen.sv
// tb_motor_step_gen
// Directed bench for motor_step_gen. Expected step rise cycles and done_int
// cycles are queued when the stimulus that causes them is driven, and the
// per-cycle monitor in tick() pops and compares them as the DUT produces them.
module tb_motor_step_gen;
    import motor_step_pkg::*;

    localparam logic [5:0] BASE = 6'h08;
    localparam int         SPC  = 100;
    localparam int         DSC  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  reg_addr;
    logic [31:0] reg_data;
    logic        reg_stb;
    logic        reg_busy;
    logic        endstop;
    logic        mot_step, mot_dir, mot_enable, move_active, endstop_hit, done_int;

    int   cycle = 0;
    int   check_cnt = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   rise_cycle = 0;
    int   strobe_cycle = 0;
    logic prev_step = 1'b0;
    int   exp_rise[$];
    int   exp_done[$];

    always #5 clk = ~clk;

    motor_step_gen #(
        .BASE_ADDR         (BASE),
        .STEP_PULSE_CYCLES (SPC),
        .DIR_SETUP_CYCLES  (DSC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .reg_stb     (reg_stb),
        .reg_busy    (reg_busy),
        .endstop     (endstop),
        .mot_step    (mot_step),
        .mot_dir     (mot_dir),
        .mot_enable  (mot_enable),
        .move_active (move_active),
        .endstop_hit (endstop_hit),
        .done_int    (done_int)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any step rise/fall or done pulse
    task automatic tick();
        int expv;
        @(negedge clk);
        cycle++;
        if (mot_step === 1'b1 && prev_step === 1'b0) begin
            rise_cycle = cycle;
            if (exp_rise.size() > 0) expv = exp_rise.pop_front();
            else expv = -1;
            checkOutput("step_rise_cycle", cycle, expv);
        end
        if (mot_step === 1'b0 && prev_step === 1'b1)
            checkOutput("step_high_width", cycle - rise_cycle, SPC);
        if (done_int !== 1'b0) begin
            if (exp_done.size() > 0) expv = exp_done.pop_front();
            else expv = -1;
            checkOutput("done_cycle", cycle, expv);
        end
        prev_step = mot_step;
    endtask

    // One-cycle write strobe; returns in the cycle after the strobe
    task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data);
        reg_addr     = addr;
        reg_data     = data;
        reg_stb      = 1'b1;
        strobe_cycle = cycle;
        tick();
        reg_stb = 1'b0;
    endtask

    task automatic expectMove(input int s, input int n, input int period, input bit with_done);
        for (int i = 0; i < n; i++)
            exp_rise.push_back(s + 1 + DSC + i * period);
        if (with_done)
            exp_done.push_back(s + DSC + n * period + 2);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (exp_done.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_within_budget", exp_done.size(), 0);
        repeat (20) tick();
        checkOutput("all_steps_seen", exp_rise.size(), 0);
        checkOutput("idle_after_move", move_active, 0);
        exp_rise.delete();
        exp_done.delete();
    endtask

    task automatic waitUntil(input int target);
        while (cycle < target) tick();
    endtask

    initial begin
        int s;
        int es_cycle;
        rst      = 1'b1;
        reg_addr = 6'd0;
        reg_data = 32'd0;
        reg_stb  = 1'b0;
        endstop  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset values");
        checkOutput("rst_mot_step", mot_step, 0);
        checkOutput("rst_mot_dir", mot_dir, 0);
        checkOutput("rst_mot_enable", mot_enable, 1);
        checkOutput("rst_move_active", move_active, 0);
        checkOutput("rst_endstop_hit", endstop_hit, 0);
        checkOutput("rst_done_int", done_int, 0);
        checkOutput("rst_reg_busy", reg_busy, 0);

        $display("[TB] three steps, period 1000, dir 1");
        applyStimulus(BASE + REG_CONTROL, 32'h1);
        checkOutput("busy_after_write", reg_busy, 1);
        checkOutput("enable_active", mot_enable, 0);
        tick();
        checkOutput("busy_clears", reg_busy, 0);
        applyStimulus(BASE + REG_PERIOD, 32'd1000);
        tick();
        applyStimulus(BASE + REG_STEPS, 32'h8000_0003);
        expectMove(strobe_cycle, 3, 1000, 1);
        checkOutput("dir_driven", mot_dir, 1);
        checkOutput("move_started", move_active, 1);
        waitDone(4000);

        $display("[TB] period below minimum is clamped");
        applyStimulus(BASE + REG_PERIOD, 32'd50);
        tick();
        applyStimulus(BASE + REG_STEPS, 32'd2);
        expectMove(strobe_cycle, 2, 2 * SPC, 1);
        checkOutput("dir_cleared", mot_dir, 0);
        waitDone(1000);

        $display("[TB] abort during second pulse");
        applyStimulus(BASE + REG_STEPS, 32'd1000);
        s = strobe_cycle;
        expectMove(s, 2, 2 * SPC, 0);
        waitUntil(s + 1 + DSC + 2 * SPC + 30);
        applyStimulus(BASE + REG_CONTROL, 32'h3);
        exp_done.push_back(s + 1 + DSC + 2 * SPC + SPC + 2);
        checkOutput("abort_keeps_enable", mot_enable, 0);
        waitDone(1000);

        $display("[TB] endstop stops move in step 4");
        applyStimulus(BASE + REG_PERIOD, 32'd300);
        tick();
        applyStimulus(BASE + REG_CONTROL, 32'hD);
        tick();
        applyStimulus(BASE + REG_STEPS, 32'd10);
        s = strobe_cycle;
        expectMove(s, 4, 300, 0);
        waitUntil(s + 1 + DSC + 3 * 300 + 150);
        endstop  = 1'b1;
        es_cycle = cycle;
        exp_done.push_back(es_cycle + 4);
        repeat (3) tick();
        checkOutput("endstop_stops_in_3", move_active, 0);
        checkOutput("endstop_hit_set", endstop_hit, 1);
        waitDone(100);
        endstop = 1'b0;
        tick();
        checkOutput("endstop_hit_sticky", endstop_hit, 1);

        $display("[TB] ignored writes during a move");
        applyStimulus(BASE + REG_CONTROL, 32'h1);
        tick();
        applyStimulus(BASE + REG_STEPS, 32'd3);
        s = strobe_cycle;
        expectMove(s, 3, 300, 1);
        checkOutput("endstop_hit_cleared", endstop_hit, 0);
        waitUntil(s + 200);
        applyStimulus(BASE + REG_STEPS, 32'h8000_0005);
        checkOutput("busy_on_dropped_steps", reg_busy, 1);
        applyStimulus(BASE + REG_CONTROL, 32'h3);
        checkOutput("busy_strobe_dropped", reg_busy, 0);
        checkOutput("dir_unchanged", mot_dir, 0);
        tick();
        applyStimulus(BASE + REG_PERIOD, 32'd1000);
        tick();
        applyStimulus(BASE + 6'd5, 32'h2);
        checkOutput("busy_out_of_window", reg_busy, 0);
        waitDone(1500);
        applyStimulus(BASE + 6'd5, 32'h1);
        tick();
        checkOutput("out_of_window_no_move", move_active, 0);
        repeat (300) tick();

        $display("[TB] new period on next move, reset mid pulse");
        applyStimulus(BASE + REG_STEPS, 32'd2);
        s = strobe_cycle;
        expectMove(s, 2, 1000, 0);
        waitUntil(s + 1 + DSC + 1000 + 40);
        rst = 1'b1;
        #1;
        checkOutput("reset_step_low", mot_step, 0);
        checkOutput("reset_enable_off", mot_enable, 1);
        checkOutput("reset_move_inactive", move_active, 0);
        prev_step = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (300) tick();
        checkOutput("reset_rises_consumed", exp_rise.size(), 0);
        exp_rise.delete();

        $display("[TB] moves that issue no steps");
        applyStimulus(BASE + REG_STEPS, 32'd5);
        exp_done.push_back(strobe_cycle + 2);
        checkOutput("enable_off_after_reset", mot_enable, 1);
        waitDone(50);
        applyStimulus(BASE + REG_CONTROL, 32'h1);
        tick();
        applyStimulus(BASE + REG_STEPS, 32'd0);
        exp_done.push_back(strobe_cycle + 2);
        waitDone(50);

        $display("[TB] period register reset to zero clamps to minimum");
        applyStimulus(BASE + REG_STEPS, 32'd1);
        expectMove(strobe_cycle, 1, 2 * SPC, 1);
        waitDone(500);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
